adc_frame_packer: RTL and testbench

Parametrised capture framer for the radar receive path. It takes NUM_CH parallel 32-bit IQ lanes per sample, plus the matching DAC lanes, from the chirp/ADC front end. It aligns the capture window to DDS latency and builds framed packets: a header beat, routed data beats, and a trailer beat. Packets are buffered in an internal FIFO and emitted as an AXI4-Stream master toward the Ethernet packetiser, all on one clock.

---
 rtl/adc_frame_packer.sv | 210 +++++++++++++++++++++
 tb/tb_adc_frame_packer.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_frame_packer.sv
// Radar capture framer: aligns the ADC/DAC capture window and emits header/data/trailer
// packets on AXI4-Stream via an internal FWFT FIFO. Optional macro: ADC_PACKER_CHECKSUM_EN.
module adc_frame_packer #(
   parameter int NUM_CH     = 2,
   parameter int LATENCY    = 2,
   parameter int FIFO_DEPTH = 16
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        capture_en,
   input  logic                        chirp_init,
   input  logic [2*NUM_CH-1:0]         route_ctrl,
   input  logic                        s_valid,
   input  logic [32*NUM_CH-1:0]        s_adc_data,
   input  logic [32*NUM_CH-1:0]        s_dac_data,
   output logic [32*NUM_CH-1:0]        m_axis_tdata,
   output logic                        m_axis_tvalid,
   output logic                        m_axis_tlast,
   output logic                        m_axis_tuser,
   input  logic                        m_axis_tready,
   output logic                        busy,
   output logic                        overflow,
   output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
   localparam int DW = 32*NUM_CH;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int LW = AW + 1;
   localparam logic [3:0] LAT4 = 4'(LATENCY);

   if (NUM_CH < 2) begin : g_bad_num_ch
      $fatal(1, "adc_frame_packer: NUM_CH must be at least 2");
   end
   if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $fatal(1, "adc_frame_packer: LATENCY must be within 0..15");
   end
   if (FIFO_DEPTH < 4 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
      $fatal(1, "adc_frame_packer: FIFO_DEPTH must be a power of 2 and at least 4");
   end
`ifdef ADC_PACKER_CHECKSUM_EN
   if (NUM_CH < 3) begin : g_bad_csum_width
      $fatal(1, "adc_frame_packer: checksum trailer needs NUM_CH >= 3");
   end
`endif

   typedef enum logic [2:0] {IDLE, ALIGN, HEADER, DATA, TRAILER} state_t;
   state_t state;

   // Only timestamp[31:0] ever leaves the block, so the low word of the 64-bit count is kept.
   logic [31:0] ts;
   logic [31:0] frame_id, sample_cnt, drop_cnt;
   logic [3:0]  lat_cnt;
   logic        cap_r, closing, abort;
   logic        rise, fall;

   logic [DW+1:0] mem [FIFO_DEPTH];
   logic [AW:0]   wr_ptr, rd_ptr, level, free;
   logic          empty, full, room, push, pop;
   logic [DW+1:0] push_word;
   logic [DW-1:0] route_beat, hdr_beat, trl_beat;
`ifdef ADC_PACKER_CHECKSUM_EN
   logic [31:0]   csum, beat_xor;
`endif

   assign rise  = capture_en & ~cap_r;
   assign fall  = ~capture_en & cap_r;
   assign level = wr_ptr - rd_ptr;
   assign free  = LW'(FIFO_DEPTH) - level;
   assign empty = (level == '0);
   assign full  = (level == LW'(FIFO_DEPTH));
   // Data beats need two free entries so the trailer always has a slot.
   assign room  = (free >= LW'(2));
   assign pop   = ~empty & m_axis_tready;

   assign m_axis_tvalid = ~empty;
   assign {m_axis_tlast, m_axis_tuser, m_axis_tdata} = empty ? '0 : mem[rd_ptr[AW-1:0]];
   assign busy       = (state != IDLE);
   assign fifo_level = level;

   // NOTE: every variable driven here gets a default first, so no latch can be inferred.
   always_comb begin
      route_beat = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         unique case (route_ctrl[2*k +: 2])
            2'b00:   route_beat[32*k +: 32] = s_adc_data[32*k +: 32];
            2'b01:   route_beat[32*k +: 32] = s_dac_data[32*k +: 32];
            2'b10:   route_beat[32*k +: 32] = sample_cnt;
            default: route_beat[32*k +: 32] = ts;
         endcase
      end
   end

`ifdef ADC_PACKER_CHECKSUM_EN
   always_comb begin
      beat_xor = '0;
      for (int k = 0; k < NUM_CH; k++) beat_xor = beat_xor ^ route_beat[32*k +: 32];
   end
`endif

   always_comb begin
      hdr_beat        = '0;
      hdr_beat[63:0]  = {ts, frame_id};
      trl_beat        = '0;
      trl_beat[63:0]  = {drop_cnt, sample_cnt};
`ifdef ADC_PACKER_CHECKSUM_EN
      trl_beat[95:64] = csum;
`endif
   end

   always_comb begin
      push      = 1'b0;
      push_word = '0;
      unique case (state)
         HEADER:  begin push = ~full;          push_word = {2'b01, hdr_beat};   end
         DATA:    begin push = s_valid & room; push_word = {2'b00, route_beat}; end
         TRAILER: begin push = ~full;          push_word = {2'b10, trl_beat};   end
         default: ;
      endcase
   end

   // NOTE: the storage array has no reset; the pointers alone define what is valid.
   always_ff @(posedge aclk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= push_word;
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + LW'(1);
         if (pop)  rd_ptr <= rd_ptr + LW'(1);
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state      <= IDLE;
         ts         <= '0;
         frame_id   <= '0;
         sample_cnt <= '0;
         drop_cnt   <= '0;
         lat_cnt    <= '0;
         cap_r      <= 1'b0;
         closing    <= 1'b0;
         abort      <= 1'b0;
         overflow   <= 1'b0;
`ifdef ADC_PACKER_CHECKSUM_EN
         csum       <= '0;
`endif
      end else begin
         // NOTE: non-blocking assignments keep every register reading pre-edge values.
         ts    <= ts + 32'd1;
         cap_r <= capture_en;
         unique case (state)
            IDLE: if (rise) begin
               lat_cnt <= LAT4;
               state   <= ALIGN;
            end
            ALIGN: begin
               // A window that closes before alignment completes still yields an empty frame.
               if (!capture_en) begin
                  abort <= 1'b1;
                  state <= HEADER;
               end else if (lat_cnt == 4'd0) state <= HEADER;
               else if (chirp_init)          lat_cnt <= LAT4;
               else                          lat_cnt <= lat_cnt - 4'd1;
            end
            HEADER: if (!full) begin
               sample_cnt <= '0;
               drop_cnt   <= '0;
               overflow   <= 1'b0;
               closing    <= 1'b0;
               abort      <= 1'b0;
`ifdef ADC_PACKER_CHECKSUM_EN
               csum       <= '0;
`endif
               state      <= abort ? TRAILER : DATA;
            end
            DATA: begin
               if (s_valid) begin
                  if (room) begin
                     sample_cnt <= sample_cnt + 32'd1;
`ifdef ADC_PACKER_CHECKSUM_EN
                     csum       <= csum ^ beat_xor;
`endif
                  end else begin
                     drop_cnt <= drop_cnt + 32'd1;
                     overflow <= 1'b1;
                  end
               end
               if (closing) begin
                  lat_cnt <= lat_cnt - 4'd1;
                  if (lat_cnt <= 4'd1) state <= TRAILER;
               end else if (fall) begin
                  if (LATENCY == 0) state <= TRAILER;
                  else begin
                     lat_cnt <= LAT4;
                     closing <= 1'b1;
                  end
               end
            end
            TRAILER: if (!full) begin
               frame_id <= frame_id + 32'd1;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_adc_frame_packer.sv
// Self-checking bench for adc_frame_packer: random sample data and routing checked against
// a packet-level model built from the framing rules (header, routed beats, trailer).
module tb_adc_frame_packer;
`ifdef ADC_PACKER_CHECKSUM_EN
   localparam int NUM_CH = 4;
`else
   localparam int NUM_CH = 2;
`endif
   localparam int LATENCY    = 2;
   localparam int FIFO_DEPTH = 4;
   localparam int DW = 32*NUM_CH;
   localparam int AW = $clog2(FIFO_DEPTH);

   logic                aclk = 1'b0;
   logic                aresetn;
   logic                capture_en, chirp_init, s_valid, m_axis_tready;
   logic [2*NUM_CH-1:0] route_ctrl;
   logic [DW-1:0]       s_adc_data, s_dac_data, m_axis_tdata;
   logic                m_axis_tvalid, m_axis_tlast, m_axis_tuser, busy, overflow;
   logic [AW:0]         fifo_level;

   adc_frame_packer #(.NUM_CH(NUM_CH), .LATENCY(LATENCY), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .aclk(aclk), .aresetn(aresetn), .capture_en(capture_en), .chirp_init(chirp_init),
      .route_ctrl(route_ctrl), .s_valid(s_valid), .s_adc_data(s_adc_data),
      .s_dac_data(s_dac_data), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .m_axis_tready(m_axis_tready), .busy(busy), .overflow(overflow),
      .fifo_level(fifo_level));

   always #5 aclk = ~aclk;

   // Cycle count since reset release: equals the DUT timestamp seen at the next rising edge.
   logic [31:0] tb_cyc;
   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) tb_cyc <= '0;
      else          tb_cyc <= tb_cyc + 32'd1;
   end

   logic [DW+1:0] got_q[$];
   logic [DW+1:0] exp_q[$];
   always begin
      @(negedge aclk);
      #2;
      if (aresetn && m_axis_tvalid && m_axis_tready)
         got_q.push_back({m_axis_tlast, m_axis_tuser, m_axis_tdata});
   end

   int          total = 0;
   int          bad   = 0;
   logic [31:0] fid, m_acc, m_drop, m_xor;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] model_beat(input logic [2*NUM_CH-1:0] rt,
         input logic [DW-1:0] adc, input logic [DW-1:0] dac,
         input logic [31:0] cnt, input logic [31:0] stamp);
      logic [DW-1:0] b;
      b = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         case (rt[2*k +: 2])
            2'd0:    b[32*k +: 32] = adc[32*k +: 32];
            2'd1:    b[32*k +: 32] = dac[32*k +: 32];
            2'd2:    b[32*k +: 32] = cnt;
            default: b[32*k +: 32] = stamp;
         endcase
      end
      return b;
   endfunction

   function automatic logic [2*NUM_CH-1:0] route_pair(input logic [1:0] even_sel,
         input logic [1:0] odd_sel);
      logic [2*NUM_CH-1:0] r;
      for (int k = 0; k < NUM_CH; k++) r[2*k +: 2] = (k % 2 == 1) ? odd_sel : even_sel;
      return r;
   endfunction

   function automatic logic [DW+1:0] header_word(input logic [31:0] stamp);
      logic [DW-1:0] h;
      h = '0;
      h[63:32] = stamp;
      h[31:0]  = fid;
      return {2'b01, h};
   endfunction

   // One sample on the current cycle; held-ready frames never pop, so occupancy is exp_q size.
   task automatic drive_sample(input bit hold);
      logic [DW-1:0] adc, dac, beat;
      for (int k = 0; k < NUM_CH; k++) begin
         adc[32*k +: 32] = $urandom;
         dac[32*k +: 32] = $urandom;
      end
      s_adc_data = adc;
      s_dac_data = dac;
      s_valid    = 1'b1;
      if (!hold || exp_q.size() <= FIFO_DEPTH - 2) begin
         beat = model_beat(route_ctrl, adc, dac, m_acc, tb_cyc);
         exp_q.push_back({2'b00, beat});
         for (int k = 0; k < NUM_CH; k++) m_xor = m_xor ^ beat[32*k +: 32];
         m_acc = m_acc + 32'd1;
      end else begin
         m_drop = m_drop + 32'd1;
      end
   endtask

   task automatic wait_header(output bit found);
      found = 1'b0;
      for (int c = 0; c < 40 && !found; c++) begin
         @(negedge aclk);
         #3;
         found = m_axis_tvalid && m_axis_tuser;
      end
      check($sformatf("f%0d_header_seen", fid), found, 1'b1);
   endtask

   task automatic finish_frame(input bit hold);
      logic [DW-1:0] trl;
      bit            done;
      int            n;
      trl = '0;
      trl[31:0]  = m_acc;
      trl[63:32] = m_drop;
`ifdef ADC_PACKER_CHECKSUM_EN
      trl[95:64] = m_xor;
`endif
      exp_q.push_back({2'b10, trl});
      done = 1'b0;
      for (int c = 0; c < 40 && !done; c++) begin
         @(negedge aclk);
         #3;
         done = !busy;
      end
      check($sformatf("f%0d_idle", fid), done, 1'b1);
      check($sformatf("f%0d_overflow", fid), overflow, m_drop != 0);
      if (hold) begin
         check($sformatf("f%0d_level_full", fid), fifo_level, exp_q.size());
         @(negedge aclk);
         m_axis_tready = 1'b1;
      end
      for (int c = 0; c < 60 && got_q.size() < exp_q.size(); c++) begin
         @(negedge aclk);
         #3;
      end
      @(negedge aclk);
      #3;
      check($sformatf("f%0d_beat_count", fid), got_q.size(), exp_q.size());
      n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check($sformatf("f%0d_b%0d_data", fid, i), got_q[i][DW-1:0], exp_q[i][DW-1:0]);
         check($sformatf("f%0d_b%0d_last_user", fid, i), got_q[i][DW+1:DW], exp_q[i][DW+1:DW]);
      end
      check($sformatf("f%0d_drained_valid", fid), m_axis_tvalid, 1'b0);
      check($sformatf("f%0d_drained_level", fid), fifo_level, 0);
      got_q.delete();
      exp_q.delete();
      fid = fid + 32'd1;
   endtask

   task automatic run_frame(input int n, input logic [2*NUM_CH-1:0] rt, input bit hold,
         input bit chirp);
      logic [31:0] stamp;
      bit          found;
      m_acc = '0; m_drop = '0; m_xor = '0;
      @(negedge aclk);
      route_ctrl    = rt;
      m_axis_tready = !hold;
      capture_en    = 1'b1;
      // Rise seen at edge R, ALIGN counts LATENCY..0, HEADER pushes at edge R+2+LATENCY.
      stamp = tb_cyc + 32'(2 + LATENCY);
      if (chirp) begin
         // Reload lands when the count is at LATENCY-1, stretching alignment by two cycles.
         @(negedge aclk);
         @(negedge aclk);
         chirp_init = 1'b1;
         @(negedge aclk);
         chirp_init = 1'b0;
         stamp = stamp + 32'd2;
      end
      exp_q.push_back(header_word(stamp));
      wait_header(found);
      for (int i = 0; i < n; ) begin
         @(negedge aclk);
         if ($urandom_range(3) == 0) s_valid = 1'b0;
         else begin
            drive_sample(hold);
            i++;
         end
      end
      @(negedge aclk);
      capture_en = 1'b0;
      drive_sample(hold);
      for (int t = 1; t < LATENCY; t++) begin
         @(negedge aclk);
         drive_sample(hold);
      end
      @(negedge aclk);
      s_valid = 1'b0;
      finish_frame(hold);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: run did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit found;
      logic [31:0] stamp;
      aresetn = 1'b0; capture_en = 1'b0; chirp_init = 1'b0; s_valid = 1'b0;
      m_axis_tready = 1'b1; route_ctrl = '0; s_adc_data = '0; s_dac_data = '0;
      fid = '0; m_acc = '0; m_drop = '0; m_xor = '0;
      repeat (3) @(negedge aclk);
      #3;
      check("rst_tvalid", m_axis_tvalid, 1'b0);
      check("rst_tdata", m_axis_tdata, '0);
      check("rst_tlast_tuser", {m_axis_tlast, m_axis_tuser}, 2'b00);
      check("rst_busy", busy, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      check("rst_level", fifo_level, 0);
      @(negedge aclk);
      aresetn = 1'b1;

      // Two ADC/DAC windows back to back, then count/timestamp routing with a chirp reload.
      run_frame(10, route_pair(2'b00, 2'b01), 1'b0, 1'b0);
      run_frame(10, route_pair(2'b00, 2'b01), 1'b0, 1'b0);
      run_frame(7, route_pair(2'b10, 2'b11), 1'b0, 1'b1);

      // Stalled sink: 6 + LATENCY samples, only two fit beside header and reserved trailer slot.
      run_frame(6, route_pair(2'b00, 2'b01), 1'b1, 1'b0);

      // Window shorter than LATENCY: header then an empty trailer.
      m_acc = '0; m_drop = '0; m_xor = '0;
      @(negedge aclk);
      capture_en = 1'b1;
      stamp = tb_cyc + 32'd2;
      @(negedge aclk);
      capture_en = 1'b0;
      exp_q.push_back(header_word(stamp));
      finish_frame(1'b0);

      // Reset in the middle of DATA discards everything and restarts frame numbering.
      m_acc = '0; m_drop = '0; m_xor = '0;
      @(negedge aclk);
      route_ctrl = route_pair(2'b01, 2'b00);
      capture_en = 1'b1;
      wait_header(found);
      repeat (3) begin
         @(negedge aclk);
         drive_sample(1'b0);
      end
      @(negedge aclk);
      aresetn = 1'b0; s_valid = 1'b0; capture_en = 1'b0;
      #3;
      check("midrst_tvalid", m_axis_tvalid, 1'b0);
      check("midrst_level", fifo_level, 0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_overflow", overflow, 1'b0);
      @(negedge aclk);
      aresetn = 1'b1;
      got_q.delete();
      exp_q.delete();
      fid = '0;
      run_frame(5, route_pair(2'b00, 2'b01), 1'b0, 1'b0);

      for (int f = 0; f < 3; f++)
         run_frame($urandom_range(12, 1), (2*NUM_CH)'($urandom), 1'b0, 1'($urandom_range(1)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
